// File: rtl/rps_match_controller.sv
// rps_match_controller
//   Player-side front end for the stone-paper-scissors game core. Collects one
//   locked move per player, launches a round with a one-cycle start pulse,
//   waits for the result (with timeout), keeps a best-of match score and
//   declares the match winner.
//
// Ports
//   clk, rst            : system clock, synchronous active-high reset
//   new_match           : pulse, clear scores and start a fresh match
//   p1_move/p1_lock     : player 1 move (00 stone, 01 paper, 10 scissors) + commit
//   p2_move/p2_lock     : player 2 move + commit
//   game_start          : one-cycle round launch to the game core
//   game_p1/game_p2     : moves presented to the game core, held until next issue
//   res_valid/res       : game core result (00 tie, 01 P1, 10 P2, 11 invalid)
//   p1_score/p2_score   : round wins per player
//   round_cnt           : completed rounds, saturating at 255
//   lock_err            : one-cycle pulse after an illegal (11) lock attempt
//   timeout_err         : sticky, a round timed out during this match
//   busy                : round in flight (ISSUE or WAIT)
//   match_over/winner   : match finished and who won (01 P1, 10 P2)
module rps_match_controller #(
    parameter int WIN_TARGET = 3,
    parameter int TIMEOUT    = 15,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               new_match,
    input  logic [1:0]         p1_move,
    input  logic               p1_lock,
    input  logic [1:0]         p2_move,
    input  logic               p2_lock,
    output logic               game_start,
    output logic [1:0]         game_p1,
    output logic [1:0]         game_p2,
    input  logic               res_valid,
    input  logic [1:0]         res,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic [7:0]         round_cnt,
    output logic               lock_err,
    output logic               timeout_err,
    output logic               busy,
    output logic               match_over,
    output logic [1:0]         winner
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_OVER    = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [1:0]         p1_lat, p2_lat;
    logic               p1_locked, p2_locked;
    logic [TW-1:0]      timer;

    logic               p1_ok, p2_ok, p1_set, p2_set, both_set;
    logic               illegal_lock, timed_out, p1_hit, p2_hit;
    logic [SCORE_W-1:0] p1_sc_nx, p2_sc_nx;

    // Lock qualification: an illegal move never sets a flag.
    assign p1_ok        = p1_lock && (p1_move != 2'b11);
    assign p2_ok        = p2_lock && (p2_move != 2'b11);
    assign p1_set       = p1_locked | p1_ok;
    assign p2_set       = p2_locked | p2_ok;
    assign both_set     = p1_set && p2_set;
    assign illegal_lock = (p1_lock && (p1_move == 2'b11)) || (p2_lock && (p2_move == 2'b11));

    // Timer was cleared on the ISSUE->WAIT edge, so the k-th WAIT edge sees k-1.
    assign timed_out = (timer == TW'(TIMEOUT - 1));

    // Candidate scores if a result is taken this cycle; 11 leaves both unchanged.
    assign p1_sc_nx = p1_score + SCORE_W'(res_valid && (res == 2'b01));
    assign p2_sc_nx = p2_score + SCORE_W'(res_valid && (res == 2'b10));
    assign p1_hit   = (p1_sc_nx == SCORE_W'(WIN_TARGET));
    assign p2_hit   = (p2_sc_nx == SCORE_W'(WIN_TARGET));

    // Outputs decoded from the state register only.
    assign game_start = (state == S_ISSUE);
    assign busy       = (state == S_ISSUE) || (state == S_WAIT);
    assign match_over = (state == S_OVER);

    always_ff @(posedge clk) begin
        if (rst) state <= S_COLLECT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_COLLECT: if (both_set) state_nx = S_ISSUE;
            S_ISSUE:   state_nx = S_WAIT;
            S_WAIT: begin
                if (res_valid)      state_nx = (p1_hit || p2_hit) ? S_OVER : S_COLLECT;
                else if (timed_out) state_nx = S_COLLECT;
            end
            S_OVER:    state_nx = S_OVER;
            default:   state_nx = S_COLLECT;
        endcase
        if (new_match) state_nx = S_COLLECT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p1_lat      <= '0;
            p2_lat      <= '0;
            p1_locked   <= 1'b0;
            p2_locked   <= 1'b0;
            game_p1     <= '0;
            game_p2     <= '0;
            p1_score    <= '0;
            p2_score    <= '0;
            round_cnt   <= '0;
            lock_err    <= 1'b0;
            timeout_err <= 1'b0;
            winner      <= '0;
            timer       <= '0;
        end else begin
            lock_err <= 1'b0;
            if (new_match) begin
                // An in-flight round is simply dropped; WAIT is left so any
                // late result is never sampled.
                p1_locked   <= 1'b0;
                p2_locked   <= 1'b0;
                p1_score    <= '0;
                p2_score    <= '0;
                round_cnt   <= '0;
                timeout_err <= 1'b0;
                winner      <= '0;
            end else begin
                case (state)
                    S_COLLECT: begin
                        // First legal commit wins; relocks are dropped.
                        if (!p1_locked && p1_ok) begin
                            p1_lat    <= p1_move;
                            p1_locked <= 1'b1;
                        end
                        if (!p2_locked && p2_ok) begin
                            p2_lat    <= p2_move;
                            p2_locked <= 1'b1;
                        end
                        lock_err <= illegal_lock;
                        if (both_set) begin
                            // Same-cycle lock bypasses the latch.
                            game_p1 <= p1_locked ? p1_lat : p1_move;
                            game_p2 <= p2_locked ? p2_lat : p2_move;
                        end
                    end
                    S_ISSUE: timer <= '0;
                    S_WAIT: begin
                        timer <= timer + 1'b1;
                        if (res_valid) begin
                            p1_score  <= p1_sc_nx;
                            p2_score  <= p2_sc_nx;
                            if (res != 2'b11 && round_cnt != 8'hFF)
                                round_cnt <= round_cnt + 8'd1;
                            p1_locked <= 1'b0;
                            p2_locked <= 1'b0;
                            if (p1_hit)      winner <= 2'b01;
                            else if (p2_hit) winner <= 2'b10;
                        end else if (timed_out) begin
                            timeout_err <= 1'b1;
                            p1_locked   <= 1'b0;
                            p2_locked   <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
